// File: rtl/lbus_pkg.sv
// Shared definitions for the two-master local register bus arbiter.
// Contents: FSM state encoding, default bus widths, the read latency ceiling
// and the symbolic master indices.
package lbus_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 32;
  localparam int RD_LAT_MAX = 7;

  // Master indices: 0 is the TRB translator, 1 is the on-chip requester.
  localparam logic M_TRB   = 1'b0;
  localparam logic M_LOCAL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT,
    ACK,
    GAP
  } state_t;

endpackage

// File: rtl/lbus_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin picker for two requesters.
// Ports:
//   req[1:0]   - request vector
//   last_grant - index of the most recently served requester
//   gnt_valid  - at least one request is pending
//   gnt_idx    - index chosen; on a tie the requester that was not served last
// Kept as its own block so the arbitration policy can be widened later
// without touching the bus sequencing.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/lbus_arbiter.sv
// lbus_arbiter: serialises single-word transactions from two masters onto the
// shared slave register bus, with round-robin fairness and fixed read latency.
// Ports:
//   clk, rst                 - bus clock, asynchronous active-high reset
//   mN_req/we/addr/wdata     - master N request (level, held until mN_ack)
//   mN_rdata, mN_ack         - master N read data and completion pulse
//   Address, DataOut         - slave bus address / write data (held until next grant)
//   Read, Write              - one-cycle slave strobes
//   DataIn                   - OR-combined slave read data
//   owner                    - master currently or last granted
//   busy                     - high whenever the FSM is not idle
// RD_LAT is the number of cycles from Read to valid DataIn (legal 1..RD_LAT_MAX).
module lbus_arbiter
  import lbus_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] DataOut,
  output logic          Read,
  output logic          Write,
  input  logic [DW-1:0] DataIn,
  output logic          owner,
  output logic          busy
);

  state_t     state;
  logic       we_q;
  logic       last_grant;
  logic [2:0] lat_cnt;
  logic       gnt_valid;
  logic       gnt_idx;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      last_grant <= M_LOCAL;  // master 0 wins the first tie
      lat_cnt    <= '0;
      Address    <= '0;
      DataOut    <= '0;
      Read       <= 1'b0;
      Write      <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      owner      <= M_TRB;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner   <= gnt_idx;
            Address <= (gnt_idx == M_LOCAL) ? m1_addr  : m0_addr;
            DataOut <= (gnt_idx == M_LOCAL) ? m1_wdata : m0_wdata;
            we_q    <= (gnt_idx == M_LOCAL) ? m1_we    : m0_we;
            // Strobes are registered, so they are raised on the way into STROBE.
            Write   <= (gnt_idx == M_LOCAL) ? m1_we    : m0_we;
            Read    <= (gnt_idx == M_LOCAL) ? ~m1_we   : ~m0_we;
            busy    <= 1'b1;
            state   <= STROBE;
          end
        end

        STROBE: begin
          Read  <= 1'b0;
          Write <= 1'b0;
          if (we_q) begin
            m0_ack <= (owner == M_TRB);
            m1_ack <= (owner == M_LOCAL);
            state  <= ACK;
          end else begin
            lat_cnt <= 3'(RD_LAT - 1);
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            // Closing edge of the last WAIT cycle: DataIn is valid now.
            if (owner == M_LOCAL) begin
              m1_rdata <= DataIn;
            end else begin
              m0_rdata <= DataIn;
            end
            m0_ack <= (owner == M_TRB);
            m1_ack <= (owner == M_LOCAL);
            state  <= ACK;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        ACK: begin
          m0_ack     <= 1'b0;
          m1_ack     <= 1'b0;
          last_grant <= owner;
          state      <= GAP;
        end

        GAP: begin
          // One dead cycle so a master dropping req after its ack is not regranted.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_arbiter.sv
// Directed testbench for lbus_arbiter. Instance "a" uses RD_LAT=1, instance "b"
// uses RD_LAT=3; both share clock and reset.
module tb_lbus_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a (RD_LAT=1)
  logic          a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [AW-1:0] a_m0_addr, a_m1_addr, a_Address;
  logic [DW-1:0] a_m0_wdata, a_m1_wdata, a_m0_rdata, a_m1_rdata, a_DataOut, a_DataIn;
  logic          a_m0_ack, a_m1_ack, a_Read, a_Write, a_owner, a_busy;

  // Instance b (RD_LAT=3)
  logic          b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [AW-1:0] b_m0_addr, b_m1_addr, b_Address;
  logic [DW-1:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_DataOut, b_DataIn;
  logic          b_m0_ack, b_m1_ack, b_Read, b_Write, b_owner, b_busy;

  lbus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
    .Address(a_Address), .DataOut(a_DataOut), .Read(a_Read), .Write(a_Write),
    .DataIn(a_DataIn), .owner(a_owner), .busy(a_busy)
  );

  lbus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .Address(b_Address), .DataOut(b_DataOut), .Read(b_Read), .Write(b_Write),
    .DataIn(b_DataIn), .owner(b_owner), .busy(b_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Strobe and ack monitors, sampled mid-cycle.
  int a_wr_cnt = 0, a_rd_cnt = 0, both_ack_cnt = 0;
  always @(negedge clk) begin
    if (a_Write) a_wr_cnt++;
    if (a_Read) a_rd_cnt++;
    if ((a_m0_ack && a_m1_ack) || (b_m0_ack && b_m1_ack)) both_ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
    {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
    a_m0_addr = '0; a_m1_addr = '0; a_m0_wdata = '0; a_m1_wdata = '0; a_DataIn = '0;
    b_m0_addr = '0; b_m1_addr = '0; b_m0_wdata = '0; b_m1_wdata = '0; b_DataIn = '0;
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if ({a_Read, a_Write, a_m0_ack, a_m1_ack, a_owner, a_busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl_a: got %b required 000000",
               {a_Read, a_Write, a_m0_ack, a_m1_ack, a_owner, a_busy});
    end
    tests_run++;
    if ({a_Address, a_DataOut, a_m0_rdata, a_m1_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data_a: Address=%h DataOut=%h rdata0=%h rdata1=%h required all 0",
               a_Address, a_DataOut, a_m0_rdata, a_m1_rdata);
    end
    tests_run++;
    if ({b_Read, b_Write, b_m0_ack, b_m1_ack, b_owner, b_busy} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl_b: got %b required 000000",
               {b_Read, b_Write, b_m0_ack, b_m1_ack, b_owner, b_busy});
    end
    rst = 1'b0;
    tick();
    $display("[TB] reset: done");
  endtask

  task automatic test_write_m0();
    int wr0, rd0;
    wr0 = a_wr_cnt; rd0 = a_rd_cnt;
    a_m0_we = 1'b1; a_m0_addr = 8'hC1; a_m0_wdata = 32'h0000_0055; a_m0_req = 1'b1;
    tick();  // cycle 1: STROBE
    tests_run++;
    if ({a_Write, a_Read, a_Address, a_DataOut, a_owner, a_busy} !== {1'b1, 1'b0, 8'hC1, 32'h55, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL write_strobe: W=%b R=%b A=%h D=%h own=%b busy=%b required W=1 R=0 A=c1 D=00000055 own=0 busy=1",
               a_Write, a_Read, a_Address, a_DataOut, a_owner, a_busy);
    end
    tick();  // cycle 2: ACK
    tests_run++;
    if ({a_m0_ack, a_m1_ack, a_Write} !== 3'b100) begin
      tests_failed++;
      $display("FAIL write_ack: m0_ack=%b m1_ack=%b Write=%b required 1 0 0", a_m0_ack, a_m1_ack, a_Write);
    end
    a_m0_req = 1'b0;
    tick();  // GAP
    tests_run++;
    if (a_m0_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ack_pulse: m0_ack=%b required 0", a_m0_ack);
    end
    tick(); tick();
    tests_run++;
    if ((a_wr_cnt - wr0) != 1 || (a_rd_cnt - rd0) != 0) begin
      tests_failed++;
      $display("FAIL write_strobe_count: writes=%0d reads=%0d required 1 0", a_wr_cnt - wr0, a_rd_cnt - rd0);
    end
    $display("[TB] write m0 addr=c1 data=00000055 done");
  endtask

  task automatic test_read_m1();
    a_m1_we = 1'b0; a_m1_addr = 8'hC2; a_m1_req = 1'b1;
    tick();  // cycle 1: STROBE
    tests_run++;
    if ({a_Read, a_Write, a_Address, a_owner} !== {1'b1, 1'b0, 8'hC2, 1'b1}) begin
      tests_failed++;
      $display("FAIL read_strobe: R=%b W=%b A=%h own=%b required R=1 W=0 A=c2 own=1",
               a_Read, a_Write, a_Address, a_owner);
    end
    tick();  // cycle 2: WAIT, slave returns data
    a_DataIn = 32'h8000_0000;
    tests_run++;
    if (a_m1_ack !== 1'b0 || a_Read !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_wait: m1_ack=%b Read=%b required 0 0", a_m1_ack, a_Read);
    end
    tick();  // cycle 3: ACK
    a_DataIn = 32'h0000_0000;
    tests_run++;
    if ({a_m1_ack, a_m0_ack, a_m1_rdata, a_m0_rdata} !== {1'b1, 1'b0, 32'h8000_0000, 32'h0}) begin
      tests_failed++;
      $display("FAIL read_ack: m1_ack=%b m0_ack=%b m1_rdata=%h m0_rdata=%h required 1 0 80000000 00000000",
               a_m1_ack, a_m0_ack, a_m1_rdata, a_m0_rdata);
    end
    a_m1_req = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (a_m1_rdata !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL read_hold: m1_rdata=%h required 80000000", a_m1_rdata);
    end
    $display("[TB] read m1 addr=c2 data=%h done", a_m1_rdata);
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    logic          exp_own;
    bit            found;
    rst = 1'b1;
    tick();
    a_m0_we = 1'b1; a_m0_addr = 8'hA0; a_m0_wdata = 32'hA0A0_A0A0;
    a_m1_we = 1'b1; a_m1_addr = 8'hB1; a_m1_wdata = 32'hB1B1_B1B1;
    a_m0_req = 1'b1; a_m1_req = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_own  = 1'(i % 2);
      exp_addr = exp_own ? 8'hB1 : 8'hA0;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        tick();
        if (a_Write) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: no Write strobe within 12 cycles", i);
      end else if (a_owner !== exp_own || a_Address !== exp_addr) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: owner=%b Address=%h required owner=%b Address=%h",
                 i, a_owner, a_Address, exp_own, exp_addr);
      end
      $display("[TB] round robin grant %0d owner=%b addr=%h", i, a_owner, a_Address);
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (both_ack_cnt != 0) begin
      tests_failed++;
      $display("FAIL rr_both_acks: cycles with both acks=%0d required 0", both_ack_cnt);
    end
  endtask

  task automatic test_rdlat3();
    b_m0_we = 1'b0; b_m0_addr = 8'h10; b_m0_req = 1'b1;
    tick();  // cycle 1: STROBE
    tests_run++;
    if ({b_Read, b_Address} !== {1'b1, 8'h10}) begin
      tests_failed++;
      $display("FAIL lat3_strobe: Read=%b Address=%h required 1 10", b_Read, b_Address);
    end
    tick(); b_DataIn = 32'h0000_AAAA;  // cycle 2
    tick();                            // cycle 3
    tick(); b_DataIn = 32'h1234_5678;  // cycle 4: 3 cycles after Read
    tests_run++;
    if (b_m0_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL lat3_early_ack: m0_ack=%b required 0 in cycle 4", b_m0_ack);
    end
    tick(); b_DataIn = 32'h0000_BBBB;  // cycle 5: ACK
    tests_run++;
    if ({b_m0_ack, b_m0_rdata} !== {1'b1, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL lat3_ack: m0_ack=%b m0_rdata=%h required 1 12345678", b_m0_ack, b_m0_rdata);
    end
    b_m0_req = 1'b0;
    tick(); tick(); tick();
    b_DataIn = '0;
    tests_run++;
    if (b_m0_rdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL lat3_hold: m0_rdata=%h required 12345678", b_m0_rdata);
    end
    $display("[TB] read lat3 addr=10 data=%h done", b_m0_rdata);
  endtask

  task automatic test_reset_mid_wait();
    bit acked;
    bit found;
    b_m0_we = 1'b0; b_m0_addr = 8'h20; b_m0_req = 1'b1;
    tick(); tick();  // now in WAIT
    rst = 1'b1;
    #1;
    tests_run++;
    if ({b_busy, b_owner, b_Read, b_Write, b_m0_ack, b_Address, b_m0_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async: busy=%b own=%b R=%b W=%b ack=%b A=%h rdata=%h required all 0",
               b_busy, b_owner, b_Read, b_Write, b_m0_ack, b_Address, b_m0_rdata);
    end
    b_m0_req = 1'b0;
    tick();
    rst = 1'b0;
    acked = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (b_m0_ack) acked = 1'b1;
    end
    tests_run++;
    if (acked) begin
      tests_failed++;
      $display("FAIL midreset_no_ack: m0_ack seen=1 required 0");
    end
    b_m0_we = 1'b1; b_m0_addr = 8'h30;
    b_m1_we = 1'b1; b_m1_addr = 8'h31;
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (b_Write) found = 1'b1;
    end
    tests_run++;
    if (!found || b_owner !== 1'b0 || b_Address !== 8'h30) begin
      tests_failed++;
      $display("FAIL midreset_tie: found=%b owner=%b Address=%h required 1 0 30", found, b_owner, b_Address);
    end
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    repeat (12) tick();
    $display("[TB] reset during wait done, first tie owner=%b", b_owner);
  endtask

  task automatic test_hold_past_ack();
    int wr0;
    wr0 = a_wr_cnt;
    a_m0_we = 1'b1; a_m0_addr = 8'h44; a_m0_wdata = 32'h0000_0099; a_m0_req = 1'b1;
    tick();  // STROBE
    tick();  // ACK
    tests_run++;
    if (a_m0_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_ack: m0_ack=%b required 1", a_m0_ack);
    end
    tick();  // GAP: master drops req now
    a_m0_req = 1'b0;
    repeat (6) tick();
    tests_run++;
    if ((a_wr_cnt - wr0) != 1 || a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_no_regrant: writes=%0d busy=%b required 1 0", a_wr_cnt - wr0, a_busy);
    end
    $display("[TB] hold past ack: writes=%0d", a_wr_cnt - wr0);
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_m1();
    test_round_robin();
    test_rdlat3();
    test_reset_mid_wait();
    test_hold_past_ack();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lbus_arbiter.md
Name: lbus_arbiter

Overview:
- Two-master arbiter for the TDC internal register bus (Address/Read/Write/SData/RData0 fabric).
- Master 0 is the TRB communications translator. Master 1 is an on-chip requester, such as a histogram scan sequencer.
- The block serialises single-word transactions onto the shared slave bus with round-robin fairness and fixed read latency.
- It sits between the masters and all Register/ClockGen/Ch48/timestatics slaves.

Parameters:
- AW, 8, address width
- DW, 32, data width
- RD_LAT, 1, cycles from Read strobe to valid DataIn (legal 1..7)

Ports:
- clk  in  1  bus clock
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  master 0 request; level, held until m0_ack
- m0_we  in  1  master 0: 1=write, 0=read; stable while m0_req
- m0_addr  in  AW  master 0 address; stable while m0_req
- m0_wdata  in  DW  master 0 write data; stable while m0_req
- m0_rdata  out  DW  master 0 read data
- m0_ack  out  1  master 0 completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1
- Address  out  AW  slave bus address
- DataOut  out  DW  slave bus write data
- Read  out  1  slave read strobe
- Write  out  1  slave write strobe
- DataIn  in  DW  OR-combined slave read data
- owner  out  1  index of the master currently or last granted
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-transaction), all values below:
  - state=IDLE
  - Read=Write=0
  - m0_ack=m1_ack=0
  - Address=0, DataOut=0
  - m0_rdata=m1_rdata=0
  - owner=0, busy=0
  - last_grant=1, so master 0 wins the first tie
  - An aborted transaction is never acked; the master must re-request.
- FSM states: IDLE, STROBE, WAIT, ACK, GAP. All outputs are registered.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the master != last_grant.
  - On grant: latch addr/wdata/we into Address/DataOut/we_q, set owner, go to STROBE.
  - If neither req is high, stay in IDLE.
- STROBE (exactly 1 cycle):
  - Write=1 if we_q, else Read=1; the other strobe stays 0.
  - Next state: WAIT if read, ACK if write.
- WAIT (reads only): lat counter runs RD_LAT cycles. In the last WAIT cycle, DataIn is captured into the owner's rdata at the closing edge.
- ACK (1 cycle):
  - owner's ack=1; last_grant<=owner.
  - Read rdata is valid in this cycle and held until that master's next read completes.
  - Writes leave rdata unchanged.
- GAP (1 cycle): no grant, so a master that drops req the cycle after ack is never regranted. Then go to IDLE.
- Address/DataOut hold their values from STROBE until the next grant. Read/Write are never high outside STROBE.
- Latency, with req sampled at IDLE edge E0:
  - strobe is in the cycle after E0
  - read ack at cycle 2+RD_LAT
  - write ack at cycle 2
  - next grant possible at edge of cycle 4+RD_LAT (read) or cycle 4 (write)
- Fairness: while both masters request continuously, grants strictly alternate.
- req dropped before ack (protocol violation): the transaction still completes and acks; there is no abort.
- m0_ack and m1_ack are never high in the same cycle.

Decomposition:
- Shared package lbus_pkg:
  - FSM state enum
  - AW/DW defaults
  - RD_LAT_MAX=7
  - master index constants M_TRB=0, M_LOCAL=1
- Sub-module rr_pick2:
  - combinational two-request round-robin picker
  - inputs: req[1:0], last_grant
  - outputs: gnt_valid, gnt_idx
  - separated so it can be widened to N masters later.

Test Plan:
- Master 0 write, m0_addr=8'hC1, m0_wdata=32'h00000055, master 1 idle → Write=1 for one cycle with Address=C1 and DataOut=00000055; m0_ack two cycles after the request edge; Read never asserts.
- Master 1 read of 8'hC2, slave model returns 32'h80000000 RD_LAT=1 after Read (RD_LAT=1) → m1_rdata=80000000 with m1_ack at cycle 3; m0_rdata stays 0.
- Both reqs high from reset, each re-requesting after its ack → grant order 0,1,0,1; no cycle with both acks high.
- RD_LAT=3 build, read of 8'h10 → DataIn sampled exactly 3 cycles after Read; ack at cycle 5; DataIn values driven in other cycles are not captured.
- rst pulsed during WAIT of master 0 read → all outputs go to reset values immediately; no m0_ack; a subsequent simultaneous request is granted to master 0.
- Master 0 holds req one cycle past ack (drops it in GAP) → no second Write/Read strobe is issued.
